ibex_regfile_readback: RTL and testbench
========================================

# ibex_regfile_readback

Debug and test readback engine for the Ibex register file. On request it walks an address range through one asynchronous read port and streams each word, with its address, over a valid/ready output. It sits beside the core's register file and shares a read-port mux with the debug module; it never drives the write port.

## Interface
- NumWords, 32: registers in the file (32 for RV32I, 16 for RV32E).
- DataWidth, 32: word width.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- start_i  in  1  begin a readback; sampled only in IDLE.
- abort_i  in  1  cancel the current readback.
- first_addr_i  in  5  first register of the range; sampled with start_i.
- last_addr_i  in  5  last register of the range, inclusive; sampled with start_i.
- raddr_o  out  5  register-file read address.
- rdata_i  in  DataWidth  register-file read data; combinational from raddr_o.
- out_valid_o  out  1  streamed word valid.
- out_ready_i  in  1  sink accepts the word.
- out_data_o  out  DataWidth  register value.
- out_addr_o  out  5  register index of out_data_o.
- out_last_o  out  1  word is the last of the range.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse after the last word is accepted.
- error_o  out  1  one-cycle pulse when a start is rejected.

## Operation
- FSM states: IDLE, FETCH, SEND.
- Registers:
  - ptr_q: next address to read.
  - end_q: last address of the range.
  - out_data_q, out_addr_q, out_last_q: the output word register.
- IDLE, start_i=1:
  - If first > last or last ≥ NumWords: pulse error_o next cycle and stay in IDLE.
  - Otherwise: ptr_q←first, end_q←last, go to FETCH.
- FETCH:
  - raddr_o=ptr_q.
  - Capture rdata_i, ptr_q and (ptr_q==end_q) into the output register.
  - ptr_q←ptr_q+1, go to SEND.
- SEND:
  - out_valid_o=1 and raddr_o=ptr_q.
  - On a handshake with out_last_o=0: capture the next word exactly as in FETCH and stay in SEND. Back-to-back, one word per cycle.
  - On a handshake with out_last_o=1: go to IDLE and pulse done_o.
  - Without a handshake: out_valid_o, out_data_o, out_addr_o and out_last_o stay stable.
- In IDLE, raddr_o=0.
- abort_i in FETCH or SEND:
  - Next state is IDLE; out_valid_o falls.
  - No done_o pulse.
  - This is the only case where out_valid_o may drop without a handshake.
  - abort_i takes priority over a simultaneous handshake; that word counts as not delivered.
- start_i while busy is ignored.
- abort_i in IDLE is ignored.
- Coherence: each word reflects the register-file content in its capture cycle. A write landing in the same cycle is not visible; no snapshot across the range.
- Address arithmetic is 5-bit. ptr_q never wraps, because end_q < NumWords ≤ 32 and the final increment is unused.

## Timing
- Reset values: every output 0; FSM in IDLE.
- start_i at edge 0: FETCH in cycle 1 (raddr_o=first), out_valid_o high from cycle 2.
- Latency from start to the first word valid: 2 cycles. Throughput: 1 word per cycle while out_ready_i=1.
- Last handshake at cycle n: done_o=1 and busy_o=0 in cycle n+1.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0; no done_o.

## Configuration
- IBEX_REGFILE_READBACK_SKIP_ZERO_EN
  - Defined:
    - Register 0 is never emitted.
    - A start with first=0 begins at 1.
    - A start with first=last=0 is accepted, sends no words and pulses done_o in the cycle after start; busy_o is high for that one cycle.
  - Undefined: register 0 is emitted like any other word; its value is whatever rdata_i returns, zero for a compliant file.

## Structure
- ibex_pkg holds:
  - typedef enum regfile_rb_state_e {RbIdle, RbFetch, RbSend};
  - localparam RegAddrW = 5.
- No sub-module; a single FSM and datapath.

## Test plan
- Range 1..3 (values 0x11, 0x22, 0x33), out_ready_i held 1 → words at cycles 2, 3, 4 with addresses 1, 2, 3; out_last_o on address 3; done_o at cycle 5.
- Range 5..6, out_ready_i low for 3 cycles on the first word → address 5, data 0xA5A5A5A5 held stable for 4 cycles, then address 6; no words lost or duplicated.
- first=7, last=4; and first=0, last=16 with NumWords=16 → error_o pulses once, busy_o stays 0, no out_valid_o.
- abort_i during the second word of range 1..8 → out_valid_o=0 and busy_o=0 next cycle, no done_o; a new start works normally.
- Range 0..2 with SKIP_ZERO_EN defined and undefined → addresses 1, 2 versus 0, 1, 2 (address 0 carries data 0).
- rst_ni asserted during SEND → all outputs 0 asynchronously; after release, start_i with range 2..2 → a single word with out_last_o=1.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared types and constants for the Ibex register-file readback engine.
package ibex_pkg;

    // Register-file index width (32 registers maximum).
    localparam int unsigned RegAddrW = 5;

    typedef enum logic [1:0] {
        RbIdle  = 2'd0,
        RbFetch = 2'd1,
        RbSend  = 2'd2
    } regfile_rb_state_e;

endpackage

// File: rtl/ibex_regfile_readback.sv
// Register-file readback engine: walks first..last through one asynchronous
// read port and streams {addr, data, last} over a valid/ready interface.
// Optional feature macro: IBEX_REGFILE_READBACK_SKIP_ZERO_EN. When it is
// defined, register 0 is never emitted, and a 0..0 range is an empty walk
// that only pulses done_o.
module ibex_regfile_readback
    import ibex_pkg::*;
#(
    parameter int unsigned NumWords  = 32,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [4:0]           first_addr_i,
    input  logic [4:0]           last_addr_i,
    output logic [4:0]           raddr_o,
    input  logic [DataWidth-1:0] rdata_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_data_o,
    output logic [4:0]           out_addr_o,
    output logic                 out_last_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o
);

    regfile_rb_state_e     state_q, state_d;
    logic [RegAddrW-1:0]   ptr_q, ptr_d;
    logic [RegAddrW-1:0]   end_q, end_d;
    logic [DataWidth-1:0]  out_data_q;
    logic [RegAddrW-1:0]   out_addr_q;
    logic                  out_last_q;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  capture_s;
    logic [RegAddrW-1:0]   raddr_s;
    logic                  range_bad_s;
    logic [RegAddrW-1:0]   first_eff_s;
    logic                  empty_s;
    logic                  fetch_empty_s;

    // A range is rejected if it runs backwards or past the end of the file.
    assign range_bad_s = (first_addr_i > last_addr_i) ||
                         (32'(last_addr_i) >= NumWords);

`ifdef IBEX_REGFILE_READBACK_SKIP_ZERO_EN
    // Register 0 is hard-wired zero, so the walk starts at 1; a 0..0 range
    // is accepted but has nothing to send (FETCH sees ptr_q > end_q).
    assign first_eff_s   = (first_addr_i == 5'd0) ? 5'd1 : first_addr_i;
    assign empty_s       = (last_addr_i == 5'd0);
    assign fetch_empty_s = (ptr_q > end_q);
`else
    assign first_eff_s   = first_addr_i;
    assign empty_s       = 1'b0;
    assign fetch_empty_s = 1'b0;
`endif

    // Next-state, pointer update, capture strobe and pulse generation.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        end_d     = end_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        capture_s = 1'b0;
        raddr_s   = ptr_q;
        case (state_q)
            RbIdle: begin
                raddr_s = 5'd0;
                if (start_i) begin
                    if (range_bad_s) begin
                        error_d = 1'b1;
                    end else begin
                        ptr_d   = first_eff_s;
                        end_d   = last_addr_i;
                        done_d  = empty_s;
                        state_d = RbFetch;
                    end
                end else begin
                    state_d = RbIdle;
                end
            end
            RbFetch: begin
                if (abort_i || fetch_empty_s) begin
                    state_d = RbIdle;
                end else begin
                    capture_s = 1'b1;
                    ptr_d     = ptr_q + 5'd1;
                    state_d   = RbSend;
                end
            end
            RbSend: begin
                if (abort_i) begin
                    // Abort wins over a simultaneous handshake.
                    state_d = RbIdle;
                end else if (out_ready_i) begin
                    if (out_last_q) begin
                        state_d = RbIdle;
                        done_d  = 1'b1;
                    end else begin
                        capture_s = 1'b1;
                        ptr_d     = ptr_q + 5'd1;
                    end
                end else begin
                    state_d = RbSend;
                end
            end
            default: begin
                state_d = RbIdle;
            end
        endcase
    end

    // Control state: FSM, range pointers and the one-cycle status pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RbIdle;
            ptr_q   <= 5'd0;
            end_q   <= 5'd0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            end_q   <= end_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Output word register: loads the word read this cycle, holds otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_data_q <= {DataWidth{1'b0}};
            out_addr_q <= 5'd0;
            out_last_q <= 1'b0;
        end else if (capture_s) begin
            out_data_q <= rdata_i;
            out_addr_q <= ptr_q;
            out_last_q <= (ptr_q == end_q);
        end else begin
            out_data_q <= out_data_q;
            out_addr_q <= out_addr_q;
            out_last_q <= out_last_q;
        end
    end

    assign raddr_o     = raddr_s;
    assign out_valid_o = (state_q == RbSend);
    assign busy_o      = (state_q != RbIdle);
    assign out_data_o  = out_data_q;
    assign out_addr_o  = out_addr_q;
    assign out_last_o  = out_last_q;
    assign done_o      = done_q;
    assign error_o     = error_q;

endmodule

// File: tb/tb_ibex_regfile_readback.sv
// Self-checking bench for ibex_regfile_readback: directed scenarios plus
// randomized ranges, back-pressure and aborts, checked against a queue of
// expected {addr, data} words derived from the range rules.
module tb_ibex_regfile_readback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start16, abort, ready;
    logic [4:0]  first_a, last_a;
    logic [4:0]  raddr, raddr16;
    logic [31:0] rdata, rdata16;
    logic        valid, last, busy, done, error;
    logic [31:0] odata;
    logic [4:0]  oaddr;
    logic        valid16, last16, busy16, done16, error16;
    logic [31:0] odata16;
    logic [4:0]  oaddr16;

    logic [31:0] regs [32];
    int n_chk  = 0;
    int n_fail = 0;

    assign rdata   = regs[raddr];
    assign rdata16 = regs[raddr16];

    always #5 clk = ~clk;

    ibex_regfile_readback #(.NumWords(32), .DataWidth(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .first_addr_i(first_a), .last_addr_i(last_a), .raddr_o(raddr),
        .rdata_i(rdata), .out_valid_o(valid), .out_ready_i(ready),
        .out_data_o(odata), .out_addr_o(oaddr), .out_last_o(last),
        .busy_o(busy), .done_o(done), .error_o(error)
    );

    ibex_regfile_readback #(.NumWords(16), .DataWidth(32)) dut16 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start16), .abort_i(abort),
        .first_addr_i(first_a), .last_addr_i(last_a), .raddr_o(raddr16),
        .rdata_i(rdata16), .out_valid_o(valid16), .out_ready_i(ready),
        .out_data_o(odata16), .out_addr_o(oaddr16), .out_last_o(last16),
        .busy_o(busy16), .done_o(done16), .error_o(error16)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_regs();
        regs[0] = 32'd0;
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
    endtask

    // rmode: 0 ready always, 1 random ready, 2 ready low for the first 3 cycles.
    // abort_at: -1 none, -2 abort in the fetch cycle, k abort while word k is shown.
    task automatic run_txn(input int fa, input int la, input int rmode, input int abort_at);
        int  q[$];
        int  eff;
        int  idx;
        int  cyc;
        bit  ok;
        bit  hs;
        bit  ab;
        ok  = (fa <= la) && (la < 32);
        eff = fa;
`ifdef IBEX_REGFILE_READBACK_SKIP_ZERO_EN
        if (eff == 0) eff = 1;
`endif
        for (int a = eff; a <= la; a++) q.push_back(a);
        first_a = 5'(fa);
        last_a  = 5'(la);
        start   = 1'b1;
        step();
        start = 1'b0;
        if (!ok) begin
            check_eq("err_pulse", error, 1);
            check_eq("err_busy", busy, 0);
            check_eq("err_valid", valid, 0);
            step();
            check_eq("err_once", error, 0);
            check_eq("err_idle", busy, 0);
            return;
        end
        check_eq("no_err", error, 0);
        check_eq("fetch_busy", busy, 1);
        check_eq("fetch_valid", valid, 0);
        if (q.size() == 0) begin
            check_eq("empty_done", done, 1);
            step();
            check_eq("empty_idle", busy, 0);
            check_eq("empty_done_once", done, 0);
            check_eq("empty_valid", valid, 0);
            return;
        end
        check_eq("fetch_raddr", raddr, 64'(eff));
        if (abort_at == -2) begin
            abort = 1'b1;
            step();
            abort = 1'b0;
            check_eq("abort_f_busy", busy, 0);
            check_eq("abort_f_valid", valid, 0);
            check_eq("abort_f_done", done, 0);
            return;
        end
        step();
        check_eq("latency_valid", valid, 1);
        idx = 0;
        cyc = 0;
        while (1) begin
            if (cyc > 300) begin
                check_eq("timeout", 0, 1);
                return;
            end
            check_eq("valid", valid, 1);
            check_eq("busy", busy, 1);
            check_eq("done_low", done, 0);
            check_eq("addr", oaddr, 64'(q[0]));
            check_eq("data", odata, regs[q[0]]);
            check_eq("last", last, (q.size() == 1) ? 1 : 0);
            if (q.size() > 1) check_eq("send_raddr", raddr, 64'(q[0] + 1));
            case (rmode)
                0:       ready = 1'b1;
                1:       ready = 1'($urandom_range(0, 1));
                2:       ready = (cyc >= 3);
                default: ready = 1'b1;
            endcase
            ab    = (idx == abort_at);
            abort = ab;
            start = ($urandom_range(0, 3) == 0);
            first_a = 5'($urandom);
            last_a  = 5'($urandom);
            hs = ready;
            step();
            abort = 1'b0;
            start = 1'b0;
            cyc++;
            if (ab) begin
                check_eq("abort_valid", valid, 0);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_done", done, 0);
                return;
            end
            if (hs) begin
                idx++;
                void'(q.pop_front());
                if (q.size() == 0) begin
                    check_eq("done_pulse", done, 1);
                    check_eq("done_busy", busy, 0);
                    check_eq("done_valid", valid, 0);
                    step();
                    check_eq("done_once", done, 0);
                    return;
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start16 = 1'b0; abort = 1'b0; ready = 1'b0;
        first_a = 5'd0; last_a = 5'd0;
        fill_regs();
        #12;
        check_eq("rst_valid", valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_error", error, 0);
        check_eq("rst_data", odata, 0);
        check_eq("rst_addr", oaddr, 0);
        check_eq("rst_last", last, 0);
        check_eq("rst_raddr", raddr, 0);
        rst_n = 1'b1;
        step();

        // Range 1..3, ready held high.
        regs[1] = 32'h11; regs[2] = 32'h22; regs[3] = 32'h33;
        run_txn(1, 3, 0, -1);
        // Range 5..6 with back-pressure on the first word.
        regs[5] = 32'hA5A5A5A5; regs[6] = 32'h5A5A5A5A;
        run_txn(5, 6, 2, -1);
        // Backwards range is rejected.
        run_txn(7, 4, 0, -1);
        // last >= NumWords on the 16-word instance is rejected.
        first_a = 5'd0; last_a = 5'd16; start16 = 1'b1;
        step();
        start16 = 1'b0;
        check_eq("e16_pulse", error16, 1);
        check_eq("e16_busy", busy16, 0);
        step();
        check_eq("e16_once", error16, 0);
        check_eq("e16_valid", valid16, 0);
        // Abort on the second word of 1..8, then a normal start.
        run_txn(1, 8, 0, 1);
        run_txn(4, 6, 0, -1);
        // Range 0..2 (register 0 reads zero).
        run_txn(0, 2, 0, -1);
        run_txn(0, 0, 0, -1);
        // Abort in IDLE is ignored.
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("idle_abort", busy, 0);

        // Reset during SEND, then a single-word range.
        first_a = 5'd1; last_a = 5'd8; start = 1'b1; ready = 1'b0;
        step();
        start = 1'b0;
        step();
        check_eq("pre_rst_valid", valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", valid, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_data", odata, 0);
        check_eq("mid_rst_addr", oaddr, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_raddr", raddr, 0);
        #2 rst_n = 1'b1;
        step();
        run_txn(2, 2, 0, -1);

        // Randomized ranges, back-pressure and aborts.
        for (int t = 0; t < 40; t++) begin
            int fa;
            int la;
            int r;
            int aat;
            fill_regs();
            fa = $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) la = $urandom_range(0, 31);
            else la = fa + $urandom_range(0, 31 - fa);
            r = $urandom_range(0, 9);
            aat = (r == 0) ? -2 : ((r < 3) ? $urandom_range(0, 2) : -1);
            run_txn(fa, la, 1, aat);
            ready = 1'b0;
            for (int g = 0; g < $urandom_range(0, 2); g++) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
